// File: rtl/fir_band_scheduler_if.sv
// Sample-in, engine request/response and band-out bundle for fir_band_scheduler.
// master = scheduler side, slave = front-end/engine/consumer side.
interface fir_band_scheduler_if #(
    parameter int unsigned NUM_BANDS  = 10,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned BAND_IDX_W = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_W-1:0]      in_sample;
    logic                          eng_req;
    logic [BAND_IDX_W-1:0]         eng_band;
    logic signed [DATA_W-1:0]      eng_sample;
    logic                          eng_done;
    logic signed [DATA_W-1:0]      eng_result;
    logic                          out_valid;
    logic [NUM_BANDS*DATA_W-1:0]   out_bands;

    modport master (
        input  in_valid, in_sample, eng_done, eng_result,
        output in_ready, eng_req, eng_band, eng_sample, out_valid, out_bands
    );

    modport slave (
        output in_valid, in_sample, eng_done, eng_result,
        input  in_ready, eng_req, eng_band, eng_sample, out_valid, out_bands
    );
endinterface

// File: rtl/fir_band_scheduler.sv
// Sequences one shared FIR engine over all equalizer bands per sample, with a response watchdog.
// Optional FIR_BAND_BYPASS_EN adds bypass_mask: masked bands skip the engine and pass the sample.
module fir_band_scheduler #(
    parameter int unsigned NUM_BANDS  = 10,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned BAND_IDX_W = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fir_band_scheduler_if.master  bus,
    input  logic                  enable,
    input  logic                  clr_err,
    output logic                  busy,
    output logic                  timeout_err,
`ifdef FIR_BAND_BYPASS_EN
    input  logic [NUM_BANDS-1:0]  bypass_mask,
`endif
    output logic [BAND_IDX_W-1:0] err_band
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BAND_IDX_W-1:0] LastBand = BAND_IDX_W'(NUM_BANDS - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StSkip, StDone} state_e;

    state_e                      state_q, state_d;
    logic [BAND_IDX_W-1:0]       band_q, band_d;
    logic signed [DATA_W-1:0]    sample_q, sample_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_BANDS*DATA_W-1:0] shadow_q, shadow_d;
    logic [NUM_BANDS*DATA_W-1:0] out_q, out_d;
    logic                        terr_q, terr_d;
    logic [BAND_IDX_W-1:0]       err_band_q, err_band_d;
    logic                        in_ready_w;
    logic                        advance;
`ifdef FIR_BAND_BYPASS_EN
    logic [NUM_BANDS-1:0]        mask_q, mask_d;
`endif

    assign in_ready_w     = enable && (state_q == StIdle);
    assign bus.in_ready   = in_ready_w;
    assign bus.eng_req    = (state_q == StIssue);
    assign bus.eng_band   = band_q;
    assign bus.eng_sample = sample_q;
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_bands  = out_q;
    assign busy           = (state_q != StIdle);
    assign timeout_err    = terr_q;
    assign err_band       = err_band_q;

    always_comb begin
        state_d    = state_q;
        band_d     = band_q;
        sample_d   = sample_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        out_d      = out_q;
        terr_d     = terr_q & ~clr_err;
        err_band_d = err_band_q;
        advance    = 1'b0;
`ifdef FIR_BAND_BYPASS_EN
        mask_d     = mask_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_w) begin
                    sample_d = bus.in_sample;
                    band_d   = '0;
                    state_d  = StIssue;
`ifdef FIR_BAND_BYPASS_EN
                    mask_d = bypass_mask;
                    if (bypass_mask[0]) state_d = StSkip;
`endif
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A completion in the same cycle as expiry takes priority over the timeout.
                if (bus.eng_done) begin
                    shadow_d[int'(band_q)*DATA_W +: DATA_W] = bus.eng_result;
                    advance = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    shadow_d[int'(band_q)*DATA_W +: DATA_W] = '0;
                    terr_d     = 1'b1;
                    err_band_d = band_q;
                    advance    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef FIR_BAND_BYPASS_EN
            StSkip: begin
                shadow_d[int'(band_q)*DATA_W +: DATA_W] = sample_q;
                advance = 1'b1;
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (band_q == LastBand) begin
                state_d = StDone;
                out_d   = shadow_d;
            end else begin
                band_d  = band_q + BAND_IDX_W'(1);
                state_d = StIssue;
`ifdef FIR_BAND_BYPASS_EN
                if (mask_q[band_d]) state_d = StSkip;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            band_q     <= '0;
            sample_q   <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            out_q      <= '0;
            terr_q     <= 1'b0;
            err_band_q <= '0;
`ifdef FIR_BAND_BYPASS_EN
            mask_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            band_q     <= band_d;
            sample_q   <= sample_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            out_q      <= out_d;
            terr_q     <= terr_d;
            err_band_q <= err_band_d;
`ifdef FIR_BAND_BYPASS_EN
            mask_q     <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_fir_band_scheduler.sv
// Directed bench for fir_band_scheduler with a fixed-latency engine model returning sample+band.
module tb_fir_band_scheduler;
    localparam int unsigned NB  = 10;
    localparam int unsigned DW  = 24;
    localparam int unsigned BIW = 4;
    localparam int unsigned D   = 1;

    logic clk = 1'b0;
    logic reset_n, enable, clr_err, busy, timeout_err;
    logic [BIW-1:0] err_band;
`ifdef FIR_BAND_BYPASS_EN
    logic [NB-1:0] bypass_mask;
`endif

    fir_band_scheduler_if #(.NUM_BANDS(NB), .DATA_W(DW), .BAND_IDX_W(BIW)) bus ();

    fir_band_scheduler #(.NUM_BANDS(NB), .DATA_W(DW), .BAND_IDX_W(BIW), .TIMEOUT(1023)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.master),
        .enable      (enable),
        .clr_err     (clr_err),
        .busy        (busy),
        .timeout_err (timeout_err),
`ifdef FIR_BAND_BYPASS_EN
        .bypass_mask (bypass_mask),
`endif
        .err_band    (err_band)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_viol = 0;
    int acc_q[$];
    int out_cyc[$];
    logic [NB*DW-1:0] frames[$];
    logic [BIW-1:0] band_seq[$];
    logic mute_en = 1'b0;
    logic [BIW-1:0] mute_band = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] band_of(input logic [NB*DW-1:0] f, input int k);
        return f[k*DW +: DW];
    endfunction

    // Monitor samples at the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
        if (bus.eng_req) band_seq.push_back(bus.eng_band);
        if (bus.out_valid) begin
            out_cyc.push_back(cyc);
            frames.push_back(bus.out_bands);
        end
        if (busy && bus.in_ready) ready_viol++;
    end

    // Engine model: eng_done D cycles after eng_req, result = sample + band.
    initial begin
        logic pend;
        int dly;
        logic [DW-1:0] ps;
        logic [BIW-1:0] pb;
        pend = 1'b0;
        dly = 0;
        ps = '0;
        pb = '0;
        bus.eng_done = 1'b0;
        bus.eng_result = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.eng_done = 1'b0;
            if (!reset_n) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                if (dly <= 1) begin
                    bus.eng_done = 1'b1;
                    bus.eng_result = ps + DW'(pb);
                    pend = 1'b0;
                end else begin
                    dly--;
                end
            end
            if (bus.eng_req && !(mute_en && bus.eng_band == mute_band)) begin
                pend = 1'b1;
                dly = D;
                ps = bus.eng_sample;
                pb = bus.eng_band;
            end
        end
    end

    task automatic send(input logic [DW-1:0] s);
        int k;
        @(posedge clk);
        #1;
        bus.in_sample = s;
        bus.in_valid = 1'b1;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            k++;
            if (k > 5000) break;
        end
        check_eq("send_accept", 64'(k <= 5000), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("frame_arrival", 64'(frames.size() >= n), 64'd1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] e;
        int k;
        reset_n = 1'b0;
        enable = 1'b0;
        clr_err = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sample = '0;
`ifdef FIR_BAND_BYPASS_EN
        bypass_mask = '0;
`endif
        wait_cycles(3);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_eng_req", 64'(bus.eng_req), 64'd0);
        check_eq("rst_out_bands", 64'(bus.out_bands != '0), 64'd0);
        check_eq("rst_timeout_err", 64'(timeout_err), 64'd0);
        check_eq("rst_err_band", 64'(err_band), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(2);
        enable = 1'b1;
        #1;
        check_eq("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Single frame, D=1
        band_seq.delete();
        send(DW'(100));
        wait_frames(1, 200);
        wait_cycles(3);
        check_eq("latency", 64'(out_cyc[0] - acc_q[0]), 64'd21);
        check_eq("out_valid_once", 64'(frames.size()), 64'd1);
        check_eq("band_seq_len", 64'(band_seq.size()), 64'd10);
        for (int b = 0; b < NB; b++) begin
            e = DW'(100 + b);
            check_eq($sformatf("f1_band%0d", b), 64'(band_of(frames[0], b)), 64'(e));
            check_eq($sformatf("f1_seq%0d", b), 64'(band_seq[b]), 64'(b));
        end

        // Back-to-back with in_valid held high
        acc_q.delete();
        out_cyc.delete();
        frames.delete();
        ready_viol = 0;
        @(posedge clk);
        #1;
        bus.in_sample = DW'(200);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (acc_q.size() < i + 1 && k < 200) begin
                @(posedge clk);
                #1;
                k++;
            end
            bus.in_sample = DW'(200 + 10 * (i + 1));
        end
        bus.in_valid = 1'b0;
        wait_frames(3, 200);
        wait_cycles(3);
        check_eq("b2b_accepts", 64'(acc_q.size()), 64'd3);
        check_eq("b2b_frames", 64'(frames.size()), 64'd3);
        check_eq("b2b_ready_while_busy", 64'(ready_viol), 64'd0);
        for (int i = 0; i < 3; i++) begin
            e = DW'(200 + 10 * i);
            check_eq($sformatf("b2b_f%0d_band0", i), 64'(band_of(frames[i], 0)), 64'(e));
            e = DW'(209 + 10 * i);
            check_eq($sformatf("b2b_f%0d_band9", i), 64'(band_of(frames[i], 9)), 64'(e));
        end
        for (int i = 0; i < 2; i++)
            check_eq($sformatf("b2b_gap%0d", i), 64'(acc_q[i + 1] - out_cyc[i]), 64'd1);

        // Engine silent on band 3
        frames.delete();
        mute_en = 1'b1;
        mute_band = BIW'(3);
        send(DW'(300));
        wait_frames(1, 3000);
        mute_en = 1'b0;
        check_eq("to_band3", 64'(band_of(frames[0], 3)), 64'd0);
        check_eq("to_band2", 64'(band_of(frames[0], 2)), 64'd302);
        check_eq("to_band4", 64'(band_of(frames[0], 4)), 64'd304);
        check_eq("to_band9", 64'(band_of(frames[0], 9)), 64'd309);
        check_eq("to_err", 64'(timeout_err), 64'd1);
        check_eq("to_err_band", 64'(err_band), 64'd3);
        wait_cycles(2);
        check_eq("to_err_sticky", 64'(timeout_err), 64'd1);
        clr_err = 1'b1;
        wait_cycles(1);
        clr_err = 1'b0;
        check_eq("clr_err", 64'(timeout_err), 64'd0);
        check_eq("clr_keeps_err_band", 64'(err_band), 64'd3);

        // Reset during band 5 WAIT
        frames.delete();
        send(DW'(400));
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            if (bus.eng_band == BIW'(5) && busy && !bus.eng_req) break;
            k++;
        end
        check_eq("mid_rst_reach_band5", 64'(k < 200), 64'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_eng_band", 64'(bus.eng_band), 64'd0);
        check_eq("mid_rst_eng_sample", 64'(bus.eng_sample), 64'd0);
        check_eq("mid_rst_out_bands", 64'(bus.out_bands != '0), 64'd0);
        check_eq("mid_rst_err_band", 64'(err_band), 64'd0);
        check_eq("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(30);
        check_eq("mid_rst_no_frame", 64'(frames.size()), 64'd0);
        band_seq.delete();
        send(DW'(500));
        wait_frames(1, 200);
        check_eq("post_rst_band0", 64'(band_of(frames[0], 0)), 64'd500);
        check_eq("post_rst_band9", 64'(band_of(frames[0], 9)), 64'd509);
        check_eq("post_rst_first_band", 64'(band_seq[0]), 64'd0);

        // Enable dropped after acceptance
        frames.delete();
        acc_q.delete();
        send(DW'(600));
        enable = 1'b0;
        bus.in_sample = DW'(700);
        bus.in_valid = 1'b1;
        wait_frames(1, 200);
        wait_cycles(5);
        check_eq("en_frame_band0", 64'(band_of(frames[0], 0)), 64'd600);
        check_eq("en_blocked_accepts", 64'(acc_q.size()), 64'd1);
        check_eq("en_in_ready_low", 64'(bus.in_ready), 64'd0);
        enable = 1'b1;
        k = 0;
        while (acc_q.size() < 2 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        bus.in_valid = 1'b0;
        wait_frames(2, 200);
        check_eq("en_resume_band0", 64'(band_of(frames[1], 0)), 64'd700);
        check_eq("en_resume_band5", 64'(band_of(frames[1], 5)), 64'd705);

`ifdef FIR_BAND_BYPASS_EN
        // Bands 0 and 2 bypassed; mask changed after acceptance must not matter
        frames.delete();
        acc_q.delete();
        out_cyc.delete();
        band_seq.delete();
        bypass_mask = NB'(10'b0000000101);
        send(DW'(-50));
        bypass_mask = '0;
        wait_frames(1, 200);
        check_eq("byp_latency", 64'(out_cyc[0] - acc_q[0]), 64'd19);
        e = DW'(-50);
        check_eq("byp_band0", 64'(band_of(frames[0], 0)), 64'(e));
        check_eq("byp_band2", 64'(band_of(frames[0], 2)), 64'(e));
        e = DW'(-49);
        check_eq("byp_band1", 64'(band_of(frames[0], 1)), 64'(e));
        e = DW'(-41);
        check_eq("byp_band9", 64'(band_of(frames[0], 9)), 64'(e));
        check_eq("byp_req_count", 64'(band_seq.size()), 64'd8);
        check_eq("byp_first_req", 64'(band_seq[0]), 64'd1);
        check_eq("byp_second_req", 64'(band_seq[1]), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
